rs_tag_freelist: RTL and testbench

Circular free list of reservation-station tags that feeds the rename map table. It supplies up to two free, non-null tags per cycle for the two dispatching instructions' destination registers and accepts up to two retired tags per cycle back from completion. Tag 8'd0 is the null tag ("value in register file") and is never stored or issued.

---
 rtl/rs_tag_freelist.sv | 137 +++++++++++++
 tb/tb_rs_tag_freelist.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_tag_freelist.sv
// rs_tag_freelist: circular free list of reservation-station tags.
// Hands out up to two non-null tags per cycle to dispatch and takes back
// up to two retired tags per cycle from completion. Tag 0 is the null tag
// and never enters the list.
module rs_tag_freelist #(
   parameter int NUM_TAGS = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       alloc1_req,
   input  logic       alloc2_req,
   input  logic       free1_valid,
   input  logic [7:0] free1_tag,
   input  logic       free2_valid,
   input  logic [7:0] free2_tag,
   output logic [7:0] tag1_out,
   output logic [7:0] tag2_out,
   output logic       tag1_valid,
   output logic       tag2_valid,
   output logic [7:0] free_count,
   output logic       error
);

   localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

   typedef logic [PTR_W-1:0] ptr_t;

   // Advance a pointer by 0..2 slots, wrapping at NUM_TAGS-1 -> 0. The
   // buffer depth need not be a power of two, so wrap explicitly.
   function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] inc);
      logic [8:0] sum;
      sum = 9'(p) + 9'(inc);
      if (sum >= 9'(NUM_TAGS)) sum = sum - 9'(NUM_TAGS);
      if (sum >= 9'(NUM_TAGS)) sum = sum - 9'(NUM_TAGS);
      return ptr_t'(sum);
   endfunction

   // Only tags 1..NUM_TAGS may be returned to the list.
   function automatic logic tag_legal(input logic [7:0] t);
      return (t != 8'd0) && (9'(t) <= 9'(NUM_TAGS));
   endfunction

   // Registered state.
   logic [7:0] mem_q [NUM_TAGS];
   logic [7:0] mem_d [NUM_TAGS];
   ptr_t       head_q, head_d;
   ptr_t       tail_q, tail_d;
   logic [7:0] count_q, count_d;
   logic       error_q, error_d;

   // Decode of the current request set.
   ptr_t       head_p1;
   ptr_t       tail_p1;
   logic       grant1, grant2;
   logic [1:0] pops;
   logic [1:0] pushes;
   logic [8:0] base_count;
   logic       free1_acc, free2_acc;
   logic       alloc_err, free_err;

   assign head_p1 = ptr_add(head_q, 2'd1);
   assign tail_p1 = ptr_add(tail_q, 2'd1);

   // Outputs depend on registered state only, so the map table sees a
   // stable tag pair for the whole cycle regardless of this cycle's requests.
   assign tag1_valid = (count_q >= 8'd1);
   assign tag2_valid = (count_q >= 8'd2);
   assign tag1_out   = tag1_valid ? mem_q[head_q]  : 8'd0;
   assign tag2_out   = tag2_valid ? mem_q[head_p1] : 8'd0;
   assign free_count = count_q;
   assign error      = error_q;

   // Grant pops, qualify pushes against tag range and capacity, and form
   // the next-state image of pointers, count, buffer and sticky error.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // this block stays purely combinational; blocking '=' is correct here
      // because later statements must see the earlier intermediate values.
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      error_d = error_q;

      grant1 = alloc1_req & tag1_valid;
      grant2 = grant1 & alloc2_req & tag2_valid;
      pops   = {1'b0, grant1} + {1'b0, grant2};

      alloc_err = (alloc1_req & ~tag1_valid) |
                  (alloc2_req & ~tag2_valid) |
                  (alloc2_req & ~alloc1_req);

      // Capacity is judged after this cycle's pops, so a full list that is
      // also popping can absorb the same number of returning tags.
      base_count = 9'(count_q) - 9'(pops);
      free1_acc  = free1_valid & tag_legal(free1_tag) &
                   (base_count < 9'(NUM_TAGS));
      free2_acc  = free2_valid & tag_legal(free2_tag) &
                   ((base_count + 9'(free1_acc)) < 9'(NUM_TAGS));
      free_err   = (free1_valid & ~free1_acc) | (free2_valid & ~free2_acc);
      pushes     = {1'b0, free1_acc} + {1'b0, free2_acc};

      // Accepted frees pack contiguously at the tail: a lone accepted free2
      // takes the tail slot itself.
      if (free1_acc) mem_d[tail_q] = free1_tag;
      if (free2_acc) mem_d[free1_acc ? tail_p1 : tail_q] = free2_tag;

      head_d  = ptr_add(head_q, pops);
      tail_d  = ptr_add(tail_q, pushes);
      count_d = 8'(base_count + 9'(pushes));
      error_d = error_q | alloc_err | free_err;
   end

   // State update; reset reloads the list with every tag 1..NUM_TAGS.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the buffer is reset because its contents are architectural:
         // the list must start out holding tags 1..NUM_TAGS in order.
         for (int i = 0; i < NUM_TAGS; i++) begin
            mem_q[i] <= 8'(i + 1);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 8'(NUM_TAGS);
         error_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so every flop
         // samples the pre-edge values regardless of statement order.
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_rs_tag_freelist.sv
// Directed bench for rs_tag_freelist with NUM_TAGS=16.
module tb_rs_tag_freelist;

   logic       clock = 1'b0;
   logic       reset;
   logic       alloc1_req, alloc2_req;
   logic       free1_valid, free2_valid;
   logic [7:0] free1_tag, free2_tag;
   logic [7:0] tag1_out, tag2_out, free_count;
   logic       tag1_valid, tag2_valid, error;

   int errors = 0;
   int checks = 0;

   rs_tag_freelist #(.NUM_TAGS(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .alloc1_req  (alloc1_req),
      .alloc2_req  (alloc2_req),
      .free1_valid (free1_valid),
      .free1_tag   (free1_tag),
      .free2_valid (free2_valid),
      .free2_tag   (free2_tag),
      .tag1_out    (tag1_out),
      .tag2_out    (tag2_out),
      .tag1_valid  (tag1_valid),
      .tag2_valid  (tag2_valid),
      .free_count  (free_count),
      .error       (error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic idle();
      alloc1_req  = 1'b0;
      alloc2_req  = 1'b0;
      free1_valid = 1'b0;
      free2_valid = 1'b0;
      free1_tag   = 8'd0;
      free2_tag   = 8'd0;
   endtask

   // One clock edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
   endtask

   task automatic set_frees(input logic v1, input logic [7:0] t1,
                            input logic v2, input logic [7:0] t2);
      free1_valid = v1;
      free1_tag   = t1;
      free2_valid = v2;
      free2_tag   = t2;
   endtask

   task automatic check_state(input string name, input int t1, input int t2,
                              input int cnt, input int err);
      check({name, ".tag1_out"},   tag1_out,   t1);
      check({name, ".tag2_out"},   tag2_out,   t2);
      check({name, ".tag1_valid"}, tag1_valid, (cnt >= 1) ? 1 : 0);
      check({name, ".tag2_valid"}, tag2_valid, (cnt >= 2) ? 1 : 0);
      check({name, ".free_count"}, free_count, cnt);
      check({name, ".error"},      error,      err);
   endtask

   // Pop 'pairs' pairs, checking each pair offered starts at first_tag.
   task automatic alloc_pairs(input string name, input int pairs,
                              input int first_tag);
      int t;
      t = first_tag;
      for (int k = 0; k < pairs; k++) begin
         alloc1_req = 1'b1;
         alloc2_req = 1'b1;
         check({name, ".pair_t1"}, tag1_out, t);
         check({name, ".pair_t2"}, tag2_out, (t % 16) + 1);
         t = ((t + 1) % 16) + 1;
         step();
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step();

      // Reset held while requests are active still yields the reset image.
      alloc1_req = 1'b1;
      alloc2_req = 1'b1;
      set_frees(1'b1, 8'd0, 1'b1, 8'd3);
      step();
      do_reset();
      check_state("reset", 1, 2, 16, 0);

      // Drain the list in pairs: (1,2)..(15,16), then empty.
      alloc_pairs("drain", 8, 1);
      check_state("empty", 0, 0, 0, 0);

      // Two frees into an empty list, then a single allocation.
      set_frees(1'b1, 8'd5, 1'b1, 8'd9);
      step();
      idle();
      check_state("refill", 5, 9, 2, 0);
      alloc1_req = 1'b1;
      step();
      idle();
      check_state("alloc1_only", 9, 0, 1, 0);

      // Empty list: free and alloc together; alloc rejected, free lands.
      alloc1_req = 1'b1;
      step();
      idle();
      check_state("drain_last", 0, 0, 0, 0);
      alloc1_req = 1'b1;
      set_frees(1'b1, 8'd4, 1'b0, 8'd0);
      step();
      idle();
      check_state("empty_free_alloc", 4, 0, 1, 1);

      // Full list: free without pop is rejected; tag 0 also rejected.
      do_reset();
      set_frees(1'b1, 8'd3, 1'b0, 8'd0);
      step();
      idle();
      check_state("full_free", 1, 2, 16, 1);
      set_frees(1'b1, 8'd0, 1'b0, 8'd0);
      step();
      idle();
      check_state("null_free", 1, 2, 16, 1);

      // Out-of-range tag is rejected even when there is room.
      do_reset();
      alloc1_req = 1'b1;
      step();
      idle();
      set_frees(1'b0, 8'd0, 1'b1, 8'd17);
      step();
      idle();
      check_state("range_free", 2, 3, 15, 1);

      // alloc2 without alloc1: nothing granted, error set.
      do_reset();
      alloc2_req = 1'b1;
      step();
      idle();
      check_state("alloc2_alone", 1, 2, 16, 1);

      // Full list, pop 2 and free 2 together: both frees accepted.
      do_reset();
      alloc1_req = 1'b1;
      alloc2_req = 1'b1;
      set_frees(1'b1, 8'd1, 1'b1, 8'd2);
      step();
      idle();
      check_state("full_swap", 3, 4, 16, 0);

      // count=1 with tag 7 at head; alloc1+alloc2 with free 12.
      do_reset();
      alloc_pairs("prep", 8, 1);
      set_frees(1'b1, 8'd7, 1'b0, 8'd0);
      step();
      idle();
      check_state("one_left", 7, 0, 1, 0);
      alloc1_req = 1'b1;
      alloc2_req = 1'b1;
      set_frees(1'b1, 8'd12, 1'b0, 8'd0);
      step();
      idle();
      check_state("one_left_pop", 12, 0, 1, 1);

      // Wrap-around: take 14, return 1..14, take all 16.
      do_reset();
      alloc_pairs("wrap_take", 7, 1);
      check_state("wrap_mid", 15, 16, 2, 0);
      for (int k = 0; k < 7; k++) begin
         set_frees(1'b1, 8'(2 * k + 1), 1'b1, 8'(2 * k + 2));
         step();
      end
      idle();
      check_state("wrap_full", 15, 16, 16, 0);
      alloc_pairs("wrap_all", 8, 15);
      check_state("wrap_empty", 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
